// File: rtl/swap_sched.sv
// Swap-request scheduler: buffers address pairs in a FIFO and issues them one at a time to the swap stage.
// Optional host write gating while a swap is in flight is enabled by defining SWAP_SCHED_WRITE_GATE_EN.
module swap_sched #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DEPTH       = 4,
  parameter int SWAP_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr_A,
  input  logic [ADDR_WIDTH-1:0]   req_addr_B,
  output logic                    swap,
  output logic [ADDR_WIDTH-1:0]   address_A,
  output logic [ADDR_WIDTH-1:0]   address_B,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(DEPTH):0]  count,
  input  logic                    host_we,
  output logic                    we,
  output logic                    host_stall
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CW-1:0]         hold_cnt;
  logic [ADDR_WIDTH-1:0] mem_a [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_b [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [ADDR_WIDTH-1:0] head_a;
  logic [ADDR_WIDTH-1:0] head_b;
  logic                  push;
  logic                  pop;

  // Readiness depends on occupancy alone, so a full FIFO never accepts even when popping.
  assign req_ready = (count < (PW+1)'(DEPTH));
  assign push      = req_valid & req_ready;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign head_a    = mem_a[rd_ptr];
  assign head_b    = mem_b[rd_ptr];

  // NOTE: FIFO storage has no reset; entries are only read after being written, and count gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= req_addr_A;
      mem_b[wr_ptr] <= req_addr_B;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pop) state_nxt = (head_a != head_b) ? S_ISSUE : S_DONE;
      S_ISSUE: state_nxt = S_HOLD;
      S_HOLD:  if (hold_cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up exactly with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      swap      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      address_A <= '0;
      address_B <= '0;
    end else begin
      state <= state_nxt;
      swap  <= (state_nxt == S_ISSUE);
      done  <= (state_nxt == S_DONE);
      busy  <= (state_nxt != S_IDLE);
      if (state == S_ISSUE) begin
        hold_cnt <= CW'(SWAP_CYCLES - 1);
      end else if ((state == S_HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      if (pop) begin
        address_A <= head_a;
        address_B <= head_b;
      end
    end
  end

`ifdef SWAP_SCHED_WRITE_GATE_EN
  assign we         = host_we & ~busy;
  assign host_stall = host_we & busy;
`else
  assign we         = host_we;
  assign host_stall = 1'b0;
`endif

endmodule

// File: tb/tb_swap_sched.sv
// Self-checking bench for swap_sched: a queue-and-job-timeline model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_swap_sched;
  localparam int AW    = 7;
  localparam int DEPTH = 4;
  localparam int SC    = 3;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr_A;
  logic [AW-1:0]   req_addr_B;
  logic            swap;
  logic [AW-1:0]   address_A;
  logic [AW-1:0]   address_B;
  logic            busy;
  logic            done;
  logic [CNTW-1:0] count;
  logic            host_we;
  logic            we;
  logic            host_stall;

  swap_sched #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .SWAP_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr_A(req_addr_A), .req_addr_B(req_addr_B), .swap(swap),
    .address_A(address_A), .address_B(address_B), .busy(busy), .done(done),
    .count(count), .host_we(host_we), .we(we), .host_stall(host_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending pairs and a job timeline. A job with A!=B occupies
  // SC+2 cycles (issue, SC hold, done); a degenerate job occupies one cycle (done only).
  // After each job one idle cycle passes before the next pop.
  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } req_t;

  req_t          q[$];
  bit            job_active = 1'b0;
  int            job_k      = 0;
  int            job_len    = 0;
  bit            job_diff   = 1'b0;
  logic [AW-1:0] cur_a      = '0;
  logic [AW-1:0] cur_b      = '0;
  int            cyc        = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge reset) begin
    bit   do_push;
    req_t r;
    if (reset) begin
      q.delete();
      job_active = 1'b0;
      job_k      = 0;
      job_len    = 0;
      job_diff   = 1'b0;
      cur_a      = '0;
      cur_b      = '0;
    end else begin
      do_push = req_valid && (q.size() < DEPTH);
      if (job_active) begin
        job_k++;
        if (job_k == job_len) job_active = 1'b0;
      end else if (q.size() != 0) begin
        r          = q.pop_front();
        cur_a      = r.a;
        cur_b      = r.b;
        job_diff   = (r.a != r.b);
        job_len    = job_diff ? SC + 2 : 1;
        job_k      = 0;
        job_active = 1'b1;
      end
      if (do_push) begin
        r.a = req_addr_A;
        r.b = req_addr_B;
        q.push_back(r);
      end
    end
  end

  // Per-cycle comparison plus event bookkeeping for the directed literal checks.
  bit cmp_en        = 1'b0;
  int last_swap_cyc = -1;
  int last_done_cyc = -1;
  int swap_total    = 0;
  int done_total    = 0;
  int busy_cycles   = 0;
  int we_low_cycles = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      logic exp_we;
      logic exp_stall;
`ifdef SWAP_SCHED_WRITE_GATE_EN
      exp_we    = host_we & ~job_active;
      exp_stall = host_we & job_active;
`else
      exp_we    = host_we;
      exp_stall = 1'b0;
`endif
      check("busy",       busy,       job_active);
      check("swap",       swap,       job_active && job_diff && (job_k == 0));
      check("done",       done,       job_active && (job_k == job_len - 1));
      check("count",      count,      q.size());
      check("req_ready",  req_ready,  q.size() < DEPTH);
      check("address_A",  address_A,  cur_a);
      check("address_B",  address_B,  cur_b);
      check("we",         we,         exp_we);
      check("host_stall", host_stall, exp_stall);
      if (swap) begin last_swap_cyc = cyc; swap_total++; end
      if (done) begin last_done_cyc = cyc; done_total++; end
      if (busy) busy_cycles++;
      if (!we)  we_low_cycles++;
    end
  end

  // One clock: note acceptance before the edge, then return just after it.
  task automatic step(output bit acc);
    @(negedge clk);
    acc = req_valid && req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  // Present one request and hold it until accepted; returns the number of refused edges.
  task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] b, output int rejects);
    bit acc;
    rejects    = 0;
    req_valid  = 1'b1;
    req_addr_A = a;
    req_addr_B = b;
    for (int i = 0; i < 200; i++) begin
      step(acc);
      if (acc) break;
      rejects++;
    end
    if (!acc) check("send_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int push_cyc;
    int rej;
    int d0;
    int s0;
    bit pend;
    bit acc;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr_A = '0;
    req_addr_B = '0;
    host_we    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check("rst_ready", req_ready, 1);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_stall", host_stall, 0);
    #2 reset = 1'b0;
    idle(2);

    // Single request 5/9 with the host writing continuously.
    host_we       = 1'b1;
    busy_cycles   = 0;
    we_low_cycles = 0;
    swap_total    = 0;
    send(7'd5, 7'd9, rej);
    push_cyc = cyc;
    idle(10);
    host_we = 1'b0;
    check("t1_swap_after_push", last_swap_cyc - push_cyc, 1);
    check("t1_done_after_swap", last_done_cyc - last_swap_cyc, 4);
    check("t1_busy_len", busy_cycles, 5);
    check("t1_swap_once", swap_total, 1);
    check("t1_addr_A", address_A, 5);
    check("t1_addr_B", address_B, 9);
`ifdef SWAP_SCHED_WRITE_GATE_EN
    check("t1_we_low", we_low_cycles, 5);
`else
    check("t1_we_low", we_low_cycles, 0);
`endif

    // Degenerate request 12/12: done in the cycle after the pop, no swap pulse.
    s0 = swap_total;
    send(7'd12, 7'd12, rej);
    push_cyc = cyc;
    idle(6);
    check("deg_no_swap", swap_total - s0, 0);
    check("deg_done_lat", last_done_cyc - push_cyc, 1);
    check("deg_addr_A", address_A, 12);
    check("deg_addr_B", address_B, 12);

    // Fill while the first job holds: 5 pushes leave 4 queued, the 6th waits for a pop.
    for (int i = 0; i < 5; i++) send(AW'(20 + i), AW'(40 + i), rej);
    check("fill_count", count, 4);
    check("fill_ready", req_ready, 0);
    send(7'd25, 7'd45, rej);
    check("fill_rejects", rej, 3);
    for (int i = 6; i < 10; i++) send(AW'(20 + i), AW'(40 + i), rej);
    idle(70);
    check("fill_drained", count, 0);

    // Push on the pop edge with two queued entries.
    send(7'd1, 7'd2, rej);
    send(7'd3, 7'd4, rej);
    send(7'd5, 7'd6, rej);
    idle(4);
    send(7'd7, 7'd8, rej);
    check("pp_count", count, 2);
    check("pp_swap", swap, 1);
    check("pp_addr_A", address_A, 3);
    idle(25);

    // Reset during hold with two requests queued.
    send(7'd10, 7'd11, rej);
    send(7'd12, 7'd13, rej);
    send(7'd14, 7'd15, rej);
    check("rh_count_before", count, 2);
    check("rh_busy_before", busy, 1);
    host_we = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("rh_count", count, 0);
    check("rh_busy", busy, 0);
    check("rh_swap", swap, 0);
    check("rh_done", done, 0);
    check("rh_ready", req_ready, 1);
    check("rh_addr_A", address_A, 0);
    check("rh_stall", host_stall, 0);
    check("rh_we", we, 1);
    d0 = done_total;
    idle(2);
    #2 reset = 1'b0;
    host_we = 1'b0;
    idle(12);
    check("rh_no_done", done_total - d0, 0);
    send(7'd30, 7'd31, rej);
    idle(8);
    check("rh_new_done", done_total - d0, 1);
    check("rh_new_addr_B", address_B, 31);

    // Randomized traffic with a holding source.
    pend = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!pend && ($urandom_range(0, 2) == 0)) begin
        pend       = 1'b1;
        req_addr_A = AW'($urandom);
        req_addr_B = ($urandom_range(0, 3) == 0) ? req_addr_A : AW'($urandom);
      end
      req_valid = pend;
      host_we   = $urandom_range(0, 1) == 1;
      step(acc);
      if (acc) pend = 1'b0;
    end
    req_valid = 1'b0;
    host_we   = 1'b0;
    idle(40);
    check("rand_drained", count, 0);
    check("rand_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
